menu_controller: RTL

- Input-side counterpart of the menu renderer: turns raw player buttons into the `selected` value the renderer draws, and decides the game mode.
- Synchronises and debounces three buttons, then runs the MENU/CONFIRM/PLAY state machine.
- Updates `selected` only on frame boundaries so the highlighted box never changes mid-frame.
- Sits between the board button inputs, the VGA timing generator (`frame_tick`) and the game core (`start_pulse`, `game_mode`, `game_over`).

---
 rtl/menu_controller.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/menu_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : menu_controller                                              |
// | Description : Input side of the start menu. Synchronises and debounces the |
// |               up/down/select buttons, keeps the highlighted selection     |
// |               (updated only on frame boundaries) and runs the             |
// |               MENU -> CONFIRM -> PLAY mode state machine.                 |
// | Ports       : clk, rst        - clock, asynchronous active-high reset     |
// |               btn_up/down/select - raw asynchronous active-high buttons  |
// |               frame_tick      - one-cycle pulse at start of vblank        |
// |               game_over       - level from game core, return to menu     |
// |               selected        - highlighted box (1 = 1P, 2 = 2P)          |
// |               menu_active     - menu renderer visible (MENU/CONFIRM)      |
// |               start_pulse     - one-cycle pulse on CONFIRM -> PLAY        |
// |               game_mode       - mode latched at select (0 none, 1, 2)     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module menu_controller #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int CONFIRM_FRAMES  = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_select,
   input  logic       frame_tick,
   input  logic       game_over,
   output logic [1:0] selected,
   output logic       menu_active,
   output logic       start_pulse,
   output logic [1:0] game_mode
);

   localparam int FC_W    = $clog2(CONFIRM_FRAMES + 1);
   localparam int BTN_UP  = 0;
   localparam int BTN_DN  = 1;
   localparam int BTN_SEL = 2;

   typedef enum logic [1:0] {
      ST_MENU    = 2'd0,
      ST_CONFIRM = 2'd1,
      ST_PLAY    = 2'd2
   } state_t;

   logic [2:0] btn_raw;
   logic [2:0] press_ev;

   assign btn_raw = {btn_select, btn_down, btn_up};

   // ---------------------------------------------------------------------
   // Per-button synchroniser, debouncer and rising-edge event generator
   // ---------------------------------------------------------------------
   generate
      for (genvar i = 0; i < 3; i++) begin : g_btn
         logic             sync1_q;
         logic             sync2_q;
         logic             stable_q;
         logic             stable_d;
         logic             stable_dly_q;
         logic             press_q;
         logic             press_d;
         logic [CNT_W-1:0] cnt_q;
         logic [CNT_W-1:0] cnt_d;

         // The counter only runs while the synchronised level disagrees
         // with the accepted level; any agreement (bounce back) restarts it.
         always_comb begin
            stable_d = stable_q;
            cnt_d    = '0;
            if (sync2_q != stable_q) begin
               if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  stable_d = sync2_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         // Event fires the cycle after the accepted level rises, once per press.
         assign press_d = stable_q & ~stable_dly_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync1_q      <= 1'b0;
               sync2_q      <= 1'b0;
               stable_q     <= 1'b0;
               stable_dly_q <= 1'b0;
               press_q      <= 1'b0;
               cnt_q        <= '0;
            end else begin
               sync1_q      <= btn_raw[i];
               sync2_q      <= sync1_q;
               stable_q     <= stable_d;
               stable_dly_q <= stable_q;
               press_q      <= press_d;
               cnt_q        <= cnt_d;
            end
         end

         assign press_ev[i] = press_q;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Mode state machine
   // ---------------------------------------------------------------------
   state_t          state_q,       state_d;
   logic [1:0]      sel_next_q,    sel_next_d;
   logic [1:0]      selected_q,    selected_d;
   logic [1:0]      game_mode_q,   game_mode_d;
   logic [FC_W-1:0] frame_cnt_q,   frame_cnt_d;
   logic            start_pulse_q, start_pulse_d;
   logic            menu_active_q, menu_active_d;

   always_comb begin
      state_d       = state_q;
      sel_next_d    = sel_next_q;
      selected_d    = selected_q;
      game_mode_d   = game_mode_q;
      frame_cnt_d   = frame_cnt_q;
      start_pulse_d = 1'b0;
      menu_active_d = menu_active_q;

      case (state_q)
         ST_MENU: begin
            menu_active_d = 1'b1;
            // Displayed value follows the pending choice only at frame
            // boundaries; an event in the same cycle shows up next frame.
            if (frame_tick) begin
               selected_d = sel_next_q;
            end
            if (press_ev[BTN_SEL]) begin
               // Mode is taken from what the player currently sees.
               state_d     = ST_CONFIRM;
               game_mode_d = selected_q;
               frame_cnt_d = '0;
            end else if (press_ev[BTN_UP] && !press_ev[BTN_DN]) begin
               sel_next_d = 2'd1;
            end else if (press_ev[BTN_DN] && !press_ev[BTN_UP]) begin
               sel_next_d = 2'd2;
            end
         end

         ST_CONFIRM: begin
            if (frame_tick) begin
               if (frame_cnt_q == FC_W'(CONFIRM_FRAMES - 1)) begin
                  state_d       = ST_PLAY;
                  start_pulse_d = 1'b1;
                  menu_active_d = 1'b0;
                  frame_cnt_d   = '0;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end

         ST_PLAY: begin
            menu_active_d = 1'b0;
            if (game_over) begin
               state_d       = ST_MENU;
               menu_active_d = 1'b1;
               game_mode_d   = 2'd0;
            end
         end

         default: begin
            state_d       = ST_MENU;
            menu_active_d = 1'b1;
            game_mode_d   = 2'd0;
            frame_cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_MENU;
         sel_next_q    <= 2'd1;
         selected_q    <= 2'd1;
         game_mode_q   <= 2'd0;
         frame_cnt_q   <= '0;
         start_pulse_q <= 1'b0;
         menu_active_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         sel_next_q    <= sel_next_d;
         selected_q    <= selected_d;
         game_mode_q   <= game_mode_d;
         frame_cnt_q   <= frame_cnt_d;
         start_pulse_q <= start_pulse_d;
         menu_active_q <= menu_active_d;
      end
   end

   assign selected    = selected_q;
   assign menu_active = menu_active_q;
   assign start_pulse = start_pulse_q;
   assign game_mode   = game_mode_q;

endmodule
`default_nettype wire
